// File: rtl/ctrl.sv
// Main control decoder for the RV32I-subset core: opcode/func3/func7 -> datapath selects.
// Latency: all selects are combinational; only load_phase is registered (one clk).
// No backpressure: a LOAD holds the PC for one extra cycle through pc_sel=10.
// Optional feature: define CTRL_AUIPC_EN to decode opcode 00101 as AUIPC.
module ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       b,
   output logic [2:0] imm_type,
   output logic       alu1_sel,
   output logic       alu2_sel,
   output logic [3:0] alu_op,
   output logic [1:0] rd_sel,
   output logic       reg_wr,
   output logic [1:0] pc_sel,
   output logic       mem_addr_sel,
   output logic       mem_wr,
   output logic [2:0] mem_type,
   output logic [2:0] cmp_op,
   output logic       load_phase
);

   // Major opcodes (instr[6:2])
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;

   // Immediate formats
   localparam logic [2:0] IMM_NONE = 3'b000;
   localparam logic [2:0] IMM_U    = 3'b001;
   localparam logic [2:0] IMM_J    = 3'b010;
   localparam logic [2:0] IMM_S    = 3'b011;
   localparam logic [2:0] IMM_I    = 3'b100;
   localparam logic [2:0] IMM_B    = 3'b101;

   // Register-file write sources
   localparam logic [1:0] RD_IMM = 2'b00;
   localparam logic [1:0] RD_PC4 = 2'b01;
   localparam logic [1:0] RD_ALU = 2'b10;
   localparam logic [1:0] RD_MEM = 2'b11;

   // Next-PC sources
   localparam logic [1:0] PC_ALU  = 2'b00;
   localparam logic [1:0] PC_PC4  = 2'b01;
   localparam logic [1:0] PC_HOLD = 2'b10;

   // Branch comparator ops
   localparam logic [2:0] CMP_BEQ  = 3'b000;
   localparam logic [2:0] CMP_BNE  = 3'b001;
   localparam logic [2:0] CMP_BLT  = 3'b010;
   localparam logic [2:0] CMP_BGE  = 3'b011;
   localparam logic [2:0] CMP_BLTU = 3'b100;
   localparam logic [2:0] CMP_BGEU = 3'b101;

   localparam logic [3:0] ALU_ADD = 4'b0000;

   logic load_phase_q;
   logic load_phase_d;

   logic is_op;
   logic is_op_imm;
   logic is_load;
   logic is_store;
   logic is_lui;
   logic is_jal;
   logic is_jalr;
   logic is_branch;
   logic is_auipc;
   logic alt_bit;

   // One-hot opcode classification shared by all select decoders
   always_comb begin
      is_op     = (opcode == OPC_OP);
      is_op_imm = (opcode == OPC_OP_IMM);
      is_load   = (opcode == OPC_LOAD);
      is_store  = (opcode == OPC_STORE);
      is_lui    = (opcode == OPC_LUI);
      is_jal    = (opcode == OPC_JAL);
      is_jalr   = (opcode == OPC_JALR);
      is_branch = (opcode == OPC_BRANCH);
`ifdef CTRL_AUIPC_EN
      is_auipc  = (opcode == OPC_AUIPC);
`else
      is_auipc  = 1'b0;
`endif
   end

   // Immediate format select
   always_comb begin
      imm_type = IMM_NONE;
      if (is_lui || is_auipc)                imm_type = IMM_U;
      else if (is_jal)                       imm_type = IMM_J;
      else if (is_store)                     imm_type = IMM_S;
      else if (is_op_imm || is_load || is_jalr) imm_type = IMM_I;
      else if (is_branch)                    imm_type = IMM_B;
   end

   // ALU operand muxes: PC as operand A for PC-relative adds, rs2 only for OP
   always_comb begin
      alu1_sel = is_jal || is_auipc;
      alu2_sel = !is_op;
   end

   // ALU op: func7[5] selects SUB only on register-register, SRA on both shift-right forms
   always_comb begin
      alt_bit = 1'b0;
      alu_op  = ALU_ADD;
      if (is_op || is_op_imm) begin
         if ((is_op && func3 == 3'b000) || func3 == 3'b101)
            alt_bit = func7[5];
         alu_op = {alt_bit, func3};
      end
   end

   // Register-file write source and enable; LOAD writes only in its second cycle
   always_comb begin
      rd_sel = RD_IMM;
      reg_wr = 1'b0;
      if (is_op || is_op_imm || is_auipc) begin
         rd_sel = RD_ALU;
         reg_wr = 1'b1;
      end else if (is_jal || is_jalr) begin
         rd_sel = RD_PC4;
         reg_wr = 1'b1;
      end else if (is_load) begin
         rd_sel = RD_MEM;
         reg_wr = load_phase_q;
      end else if (is_lui) begin
         rd_sel = RD_IMM;
         reg_wr = 1'b1;
      end
   end

   // Next-PC source: jumps/taken branches use the ALU target, LOAD phase 0 holds PC
   always_comb begin
      pc_sel = PC_PC4;
      if (is_jal || is_jalr)          pc_sel = PC_ALU;
      else if (is_branch && b)        pc_sel = PC_ALU;
      else if (is_load && !load_phase_q) pc_sel = PC_HOLD;
   end

   // Memory port controls: the data address is presented in LOAD phase 0
   always_comb begin
      mem_addr_sel = is_load && !load_phase_q;
      mem_wr       = is_store;
      mem_type     = (is_load || is_store) ? func3 : 3'b000;
   end

   // Branch comparator op from func3, independent of opcode
   always_comb begin
      cmp_op = CMP_BEQ;
      case (func3)
         3'b000:  cmp_op = CMP_BEQ;
         3'b001:  cmp_op = CMP_BNE;
         3'b100:  cmp_op = CMP_BLT;
         3'b101:  cmp_op = CMP_BGE;
         3'b110:  cmp_op = CMP_BLTU;
         3'b111:  cmp_op = CMP_BGEU;
         default: cmp_op = CMP_BEQ;
      endcase
   end

   // Next load phase: toggles while LOAD is held, otherwise returns to phase 0
   always_comb begin
      load_phase_d = is_load ? !load_phase_q : 1'b0;
   end

   // Load phase register with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) load_phase_q <= 1'b0;
      else     load_phase_q <= load_phase_d;
   end

   assign load_phase = load_phase_q;

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl: directed steps followed by randomized decode.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Expected values come from a reference decoder built from the opcode rules.
module tb_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] opcode = 5'b01100;
   logic [2:0] func3 = 3'b000;
   logic [6:0] func7 = 7'b0;
   logic       b = 1'b0;
   logic [2:0] imm_type;
   logic       alu1_sel;
   logic       alu2_sel;
   logic [3:0] alu_op;
   logic [1:0] rd_sel;
   logic       reg_wr;
   logic [1:0] pc_sel;
   logic       mem_addr_sel;
   logic       mem_wr;
   logic [2:0] mem_type;
   logic [2:0] cmp_op;
   logic       load_phase;

   int total = 0;
   int bad   = 0;
   int load_run = 0;   // consecutive LOAD edges seen outside reset

   ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
      .imm_type(imm_type), .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .alu_op(alu_op),
      .rd_sel(rd_sel), .reg_wr(reg_wr), .pc_sel(pc_sel), .mem_addr_sel(mem_addr_sel),
      .mem_wr(mem_wr), .mem_type(mem_type), .cmp_op(cmp_op), .load_phase(load_phase)
   );

   always #5 clk = ~clk;

   logic [22:0] dut_vec;
   assign dut_vec = {imm_type, alu1_sel, alu2_sel, alu_op, rd_sel, reg_wr, pc_sel,
                     mem_addr_sel, mem_wr, mem_type, cmp_op, load_phase};

   // Reference decoder: each output derived from instruction semantics.
   function automatic logic [22:0] model(input logic [4:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic bb,
                                         input logic ph);
      logic [2:0] imm; logic a1, a2; logic [3:0] aop; logic [1:0] rs; logic wr;
      logic [1:0] pcs; logic mas, mw; logic [2:0] mt, cmp;
      string name;
      case (opc)
         5'b01100: name = "OP";
         5'b00100: name = "OPIMM";
         5'b00000: name = "LOAD";
         5'b01000: name = "STORE";
         5'b01101: name = "LUI";
         5'b11011: name = "JAL";
         5'b11001: name = "JALR";
         5'b11000: name = "BRANCH";
`ifdef CTRL_AUIPC_EN
         5'b00101: name = "AUIPC";
`endif
         default:  name = "UNK";
      endcase
      imm = 3'b000; a1 = 1'b0; a2 = (name != "OP"); aop = 4'b0000;
      rs = 2'b00; wr = 1'b0; pcs = 2'b01; mas = 1'b0; mw = 1'b0; mt = 3'b000;
      if (name == "LUI")    begin imm = 3'b001; wr = 1'b1; end
      if (name == "AUIPC")  begin imm = 3'b001; a1 = 1'b1; rs = 2'b10; wr = 1'b1; end
      if (name == "JAL")    begin imm = 3'b010; a1 = 1'b1; rs = 2'b01; wr = 1'b1; pcs = 2'b00; end
      if (name == "JALR")   begin imm = 3'b100; rs = 2'b01; wr = 1'b1; pcs = 2'b00; end
      if (name == "STORE")  begin imm = 3'b011; mw = 1'b1; mt = f3; end
      if (name == "BRANCH") begin imm = 3'b101; pcs = bb ? 2'b00 : 2'b01; end
      if (name == "LOAD") begin
         imm = 3'b100; rs = 2'b11; wr = ph; mt = f3;
         pcs = ph ? 2'b01 : 2'b10; mas = !ph;
      end
      if (name == "OP") begin
         rs = 2'b10; wr = 1'b1;
         aop = (f3 == 3'b000 || f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
      end
      if (name == "OPIMM") begin
         imm = 3'b100; rs = 2'b10; wr = 1'b1;
         aop = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
      end
      case (f3)
         3'b001: cmp = 3'b001;
         3'b100: cmp = 3'b010;
         3'b101: cmp = 3'b011;
         3'b110: cmp = 3'b100;
         3'b111: cmp = 3'b101;
         default: cmp = 3'b000;
      endcase
      return {imm, a1, a2, aop, rs, wr, pcs, mas, mw, mt, cmp, ph};
   endfunction

   task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, account for the rising edge just passed,
   // apply new inputs and compare every output against the reference.
   task automatic step(input string tag, input logic [4:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic bb, input logic r);
      @(negedge clk);
      if (rst) load_run = 0;
      else     load_run = (opcode == 5'b00000) ? load_run + 1 : 0;
      rst = r; opcode = opc; func3 = f3; func7 = f7; b = bb;
      if (r) load_run = 0;
      #1;
      chk(tag, dut_vec, model(opc, f3, f7, bb, load_run[0]));
   endtask

   initial begin
      // Reset state
      step("reset", 5'b01100, 3'b000, 7'h00, 1'b0, 1'b1);
      chk("reset_phase", {22'd0, load_phase}, 23'd0);
      step("reset_hold", 5'b01100, 3'b000, 7'h00, 1'b0, 1'b0);

      // Opcode sweep
      step("lui", 5'b01101, 3'b010, 7'h11, 1'b0, 1'b0);
      chk("lui_imm", {20'd0, imm_type}, 23'd1);
      step("opimm", 5'b00100, 3'b110, 7'h00, 1'b0, 1'b0);
      chk("opimm_sel", {17'd0, imm_type, alu2_sel, rd_sel, reg_wr}, {17'd0, 3'b100, 1'b1, 2'b10, 1'b1});
      step("store", 5'b01000, 3'b010, 7'h00, 1'b0, 1'b0);
      chk("store_sel", {18'd0, imm_type, reg_wr, mem_wr}, {18'd0, 3'b011, 1'b0, 1'b1});

      // Operand muxes
      step("jal", 5'b11011, 3'b000, 7'h00, 1'b0, 1'b0);
      chk("jal_sel", {18'd0, alu1_sel, rd_sel, pc_sel}, {18'd0, 1'b1, 2'b01, 2'b00});
      step("load_sweep", 5'b00000, 3'b100, 7'h00, 1'b0, 1'b0);
      chk("load_sel", {20'd0, alu1_sel, rd_sel}, {20'd0, 1'b0, 2'b11});
      step("op", 5'b01100, 3'b111, 7'h00, 1'b0, 1'b0);
      chk("op_alu2", {22'd0, alu2_sel}, 23'd0);
      step("unknown", 5'b10101, 3'b000, 7'h00, 1'b0, 1'b0);
      chk("unk_sel", {21'd0, alu2_sel, reg_wr}, {21'd0, 1'b1, 1'b0});
      step("auipc_slot", 5'b00101, 3'b000, 7'h00, 1'b0, 1'b0);

      // ALU op
      step("op_sub", 5'b01100, 3'b000, 7'h20, 1'b0, 1'b0);
      chk("op_sub_aluop", {19'd0, alu_op}, 23'b1000);
      step("opimm_add", 5'b00100, 3'b000, 7'h20, 1'b0, 1'b0);
      chk("opimm_add_aluop", {19'd0, alu_op}, 23'b0000);
      step("opimm_sra", 5'b00100, 3'b101, 7'h20, 1'b0, 1'b0);
      chk("opimm_sra_aluop", {19'd0, alu_op}, 23'b1101);

      // Branch / jump
      step("jalr", 5'b11001, 3'b000, 7'h00, 1'b0, 1'b0);
      chk("jalr_pc", {21'd0, pc_sel}, 23'b00);
      step("br_nt", 5'b11000, 3'b001, 7'h00, 1'b0, 1'b0);
      chk("br_nt_pc", {21'd0, pc_sel}, 23'b01);
      step("br_t", 5'b11000, 3'b001, 7'h00, 1'b1, 1'b0);
      chk("br_t_pc", {21'd0, pc_sel}, 23'b00);

      // LOAD phasing through reset
      step("ld_rst0", 5'b00000, 3'b010, 7'h00, 1'b0, 1'b1);
      step("ld_rst1", 5'b00000, 3'b010, 7'h00, 1'b0, 1'b1);
      chk("ld_rst_sel", {18'd0, load_phase, pc_sel, mem_addr_sel, reg_wr}, {18'd0, 1'b0, 2'b10, 1'b1, 1'b0});
      step("ld_rel", 5'b00000, 3'b010, 7'h00, 1'b0, 1'b0);
      step("ld_ph1", 5'b00000, 3'b010, 7'h00, 1'b0, 1'b0);
      chk("ld_ph1_sel", {18'd0, load_phase, pc_sel, reg_wr, mem_addr_sel}, {18'd0, 1'b1, 2'b01, 1'b1, 1'b0});
      step("ld_ph0", 5'b00000, 3'b010, 7'h00, 1'b0, 1'b0);
      chk("ld_ph0_bit", {22'd0, load_phase}, 23'd0);
      step("ld_ph1b", 5'b00000, 3'b010, 7'h00, 1'b0, 1'b0);
      step("ld_leave", 5'b01100, 3'b000, 7'h00, 1'b0, 1'b0);
      step("ld_left", 5'b01100, 3'b000, 7'h00, 1'b0, 1'b0);
      chk("ld_left_bit", {22'd0, load_phase}, 23'd0);
      step("ld_midrst_a", 5'b00000, 3'b000, 7'h00, 1'b0, 1'b0);
      step("ld_midrst_b", 5'b00000, 3'b000, 7'h00, 1'b0, 1'b0);
      step("ld_midrst_c", 5'b00000, 3'b000, 7'h00, 1'b0, 1'b1);
      chk("ld_midrst_sel", {20'd0, load_phase, pc_sel}, {20'd0, 1'b0, 2'b10});

      // Comparator with opcode=LOAD
      step("cmp110", 5'b00000, 3'b110, 7'h00, 1'b0, 1'b0);
      chk("cmp110_op", {20'd0, cmp_op}, 23'b100);
      step("cmp101", 5'b00000, 3'b101, 7'h00, 1'b0, 1'b0);
      chk("cmp101_op", {20'd0, cmp_op}, 23'b011);
      step("cmp000", 5'b00000, 3'b000, 7'h00, 1'b0, 1'b0);
      chk("cmp000_op", {20'd0, cmp_op}, 23'b000);

      // Randomized decode, biased toward known opcodes and LOAD runs
      for (int i = 0; i < 400; i++) begin
         logic [4:0] opc;
         logic [4:0] known [9];
         known = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b01101,
                   5'b11011, 5'b11001, 5'b11000, 5'b00101};
         if ($urandom_range(0, 3) == 0) opc = 5'($urandom);
         else if ($urandom_range(0, 2) == 0) opc = 5'b00000;
         else opc = known[$urandom_range(0, 8)];
         step("rand", opc, 3'($urandom), 7'($urandom), 1'($urandom),
              ($urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctrl.md
Name: ctrl

Overview:
- Main control decoder of the single-issue RV32I-subset core (MPU datapath).
- Decodes the 5-bit major opcode (instr[6:2]), func3 and func7 into datapath selects: immediate type, ALU operand muxes, ALU op, register-file write enable and source, PC source, memory address/write controls, and branch comparator op.
- Holds one state bit, load_phase, which stretches LOAD to two cycles.

Parameters:
- None.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; asynchronous, active-high; clears load_phase
- opcode  in  5  instr[6:2]
- func3  in  3  instr[14:12]
- func7  in  7  instr[31:25]
- b  in  1  branch comparator result (1 = condition true / taken)
- imm_type  out  3  immediate format select
- alu1_sel  out  1  ALU operand A: 0 = rs1, 1 = PC
- alu2_sel  out  1  ALU operand B: 0 = rs2, 1 = immediate
- alu_op  out  4  ALU operation
- rd_sel  out  2  register-file write source
- reg_wr  out  1  register-file write enable
- pc_sel  out  2  next-PC source
- mem_addr_sel  out  1  memory address: 0 = PC (fetch), 1 = ALU result (data)
- mem_wr  out  1  data memory write strobe
- mem_type  out  3  access width/sign (func3 during LOAD/STORE, else 3'b000)
- cmp_op  out  3  branch comparator operation
- load_phase  out  1  LOAD phase state bit

Behaviour:
- All outputs are combinational from opcode/func3/func7/b/load_phase, except load_phase, which is registered.
- Opcodes: OP 01100, OP_IMM 00100, LOAD 00000, STORE 01000, LUI 01101, JAL 11011, JALR 11001, BRANCH 11000. Any other opcode is unknown.
- imm_type:
  - LUI -> 001 (U)
  - JAL -> 010 (J)
  - STORE -> 011 (S)
  - OP_IMM, LOAD, JALR -> 100 (I)
  - BRANCH -> 101 (B)
  - else 000
- alu1_sel: 1 for JAL; 0 otherwise.
- alu2_sel: 0 only for OP; 1 for every other opcode, including unknown ones.
- alu_op:
  - OP/OP_IMM: {bit5, func3}, where bit5 = func7[5] when (OP and func3=000) or func3=101; else bit5 = 0.
  - Encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - All other opcodes -> 0000 (ADD).
- rd_sel:
  - OP, OP_IMM -> 10 (ALU)
  - JAL, JALR -> 01 (PC+4)
  - LOAD -> 11 (memory)
  - LUI -> 00 (immediate)
  - else 00
- reg_wr:
  - 1 for OP, OP_IMM, LUI, JAL, JALR
  - 0 for STORE, BRANCH and unknown opcodes
  - LOAD: equals load_phase (writes in the second cycle only)
- load_phase:
  - Async clear on rst.
  - At each rising clk with rst low: next = ~load_phase if opcode==LOAD, else 0.
  - A LOAD therefore occupies phase 0 then phase 1.
- pc_sel:
  - 00 (ALU target) for JAL, JALR, and BRANCH with b=1
  - 01 (PC+4) for BRANCH with b=0, LOAD with load_phase=1, and all other opcodes
  - 10 (hold PC) for LOAD with load_phase=0
- mem_addr_sel: 1 when opcode==LOAD and load_phase=0; 0 otherwise.
- mem_wr: 1 only for STORE.
- cmp_op: decoded from func3 regardless of opcode.
  - 000 -> 000 (BEQ)
  - 001 -> 001 (BNE)
  - 100 -> 010 (BLT)
  - 101 -> 011 (BGE)
  - 110 -> 100 (BLTU)
  - 111 -> 101 (BGEU)
  - 010/011 -> 000
- Reset mid-LOAD: load_phase forces to 0 immediately, so pc_sel=10 and reg_wr=0 while rst is high.
- Opcode changing away from LOAD in phase 1: load_phase clears on the next edge.

Optional Feature:
- Macro CTRL_AUIPC_EN.
- Defined: opcode 00101 (AUIPC) decodes as imm_type=001, alu1_sel=1, alu2_sel=1, alu_op=0000, rd_sel=10, reg_wr=1, pc_sel=01.
- Undefined: 00101 is an unknown opcode: imm_type=000, alu1_sel=0, alu2_sel=1, rd_sel=00, reg_wr=0, pc_sel=01, mem_wr=0.

Test Plan:
- Opcode sweep:
  - LUI -> imm_type=001
  - OP_IMM -> imm_type=100, alu2_sel=1, rd_sel=10, reg_wr=1
  - STORE -> imm_type=011, reg_wr=0, mem_wr=1
- Operand muxes:
  - JAL -> alu1_sel=1, rd_sel=01, pc_sel=00
  - LOAD -> alu1_sel=0, rd_sel=11
  - OP -> alu2_sel=0
  - opcode 10101 -> alu2_sel=1, reg_wr=0
- ALU op:
  - OP func3=000 func7=0100000 -> alu_op=1000
  - OP_IMM func3=000 func7=0100000 -> alu_op=0000
  - OP_IMM func3=101 func7=0100000 -> alu_op=1101
- Branch/jump:
  - JALR -> pc_sel=00
  - BRANCH b=0 -> pc_sel=01
  - BRANCH b=1 -> pc_sel=00
- LOAD phasing:
  - opcode=LOAD with rst=1 for 2 cycles -> load_phase=0, pc_sel=10, mem_addr_sel=1, reg_wr=0
  - Release rst, one rising edge -> load_phase=1, pc_sel=01, reg_wr=1, mem_addr_sel=0
  - Next edge -> load_phase=0
- Comparator: func3 110 -> cmp_op=100; 101 -> 011; 000 -> 000 (with opcode=LOAD).
